// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D
    } arb_state_t;

    localparam logic [2:0] SIZE_WORD = 3'b010;
    localparam int REQ_ADDR_W = 64;

    // Widest supported address; narrower ADDR_W values are zero-extended in.
    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic [2:0]            size;
        logic [7:0]            strobe;
        logic [63:0]           wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_bus_arbiter_starve_counter.sv
// Saturating count of data grants taken while an instruction request waits.
module arb_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic incr,
    output logic at_limit
);

    localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [W-1:0] MAX = W'(LIMIT);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr && count != MAX) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == MAX);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch and data channels,
// data first, with a bound on how long instruction fetch can starve.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_data_ok,
    output logic [31:0]       i_data,
    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [2:0]        d_size,
    input  logic [7:0]        d_strobe,
    input  logic [63:0]       d_wdata,
    output logic              d_data_ok,
    output logic [63:0]       d_rdata,
    output logic              m_valid,
    output logic [ADDR_W-1:0] m_addr,
    output logic [2:0]        m_size,
    output logic [7:0]        m_strobe,
    output logic [63:0]       m_wdata,
    input  logic              m_data_ok,
    input  logic [63:0]       m_rdata
);

    arb_state_t state;
    mem_req_t   req;

    logic idle;
    logic at_limit;
    logic grant_i;
    logic grant_d;
    logic cnt_clear;
    logic cnt_incr;

    assign idle    = (state == IDLE);
    assign grant_i = idle && i_valid && (!d_valid || at_limit);
    assign grant_d = idle && d_valid && !grant_i;

    // A data grant only counts as starvation when fetch is also waiting.
    assign cnt_clear = idle && (!i_valid || grant_i);
    assign cnt_incr  = grant_d && i_valid;

    arb_starve_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .incr    (cnt_incr),
        .at_limit(at_limit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            m_valid <= 1'b0;
            req     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_i) begin
                        state   <= GRANT_I;
                        m_valid <= 1'b1;
                        req     <= '{addr:   REQ_ADDR_W'(i_addr),
                                     size:   SIZE_WORD,
                                     strobe: 8'h00,
                                     wdata:  64'h0};
                    end else if (grant_d) begin
                        state   <= GRANT_D;
                        m_valid <= 1'b1;
                        req     <= '{addr:   REQ_ADDR_W'(d_addr),
                                     size:   d_size,
                                     strobe: d_strobe,
                                     wdata:  d_wdata};
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (m_data_ok) begin
                        state   <= IDLE;
                        m_valid <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

    assign m_addr   = req.addr[ADDR_W-1:0];
    assign m_size   = req.size;
    assign m_strobe = req.strobe;
    assign m_wdata  = req.wdata;

    assign i_data_ok = (state == GRANT_I) && m_data_ok;
    assign d_data_ok = (state == GRANT_D) && m_data_ok;

    assign i_data  = !i_data_ok ? 32'h0 :
                     req.addr[2] ? m_rdata[63:32] : m_rdata[31:0];
    assign d_rdata = d_data_ok ? m_rdata : 64'h0;

endmodule
